rx_am_lock: RTL and testbench

RX_AM_LOCK -- requirements
Module: rx_am_lock

---
 rtl/rx_am_lock.sv | 174 +++++++++++++++++
 tb/tb_rx_am_lock.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/rx_am_lock.sv
// Alignment-marker lock for one PCS lane: finds, confirms and tracks AMs.
// Matched AMs are stripped from the block stream once the lane is locked.
module rx_am_lock #(
  parameter int AM_PERIOD = 16384
) (
  input  logic        core_clk,
  input  logic        core_reset_n,
  input  logic        block_locked,
  input  logic        block_valid,
  input  logic [65:0] block_in,
  output logic [65:0] block_out,
  output logic        block_out_valid,
  output logic        am_strobe,
  output logic        am_lock,
  output logic [1:0]  lane_id
);

  localparam int CW = $clog2(AM_PERIOD) + 1;

  typedef enum logic [1:0] {
    INIT,
    FIND_1ST,
    COUNT_1,
    LOCKED
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  inv_q, inv_d;
  logic [1:0]  rec_q, rec_d;
  logic [1:0]  lane_id_q, lane_id_d;
  logic        am_lock_q, am_lock_d;
  logic        am_strobe_q, am_strobe_d;
  logic        bov_q, bov_d;
  logic [65:0] bout_q, bout_d;

  logic [3:0]  lane_hit;
  logic        hit_any;
  logic [1:0]  hit_idx;
  logic        exp_pos;
  logic        hit_lid;
  logic        hit_rec;
  logic        am_take;

  // {M2, M1, M0} for each PCS lane
  function automatic logic [23:0] lane_bytes(input logic [1:0] n);
    lane_bytes = '0;
    unique case (n)
      2'd0: lane_bytes = 24'h47_76_90;
      2'd1: lane_bytes = 24'hE6_C4_F0;
      2'd2: lane_bytes = 24'h9B_65_C5;
      2'd3: lane_bytes = 24'h3D_79_A2;
    endcase
  endfunction

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lane_hit[i] = (block_in[1:0] == 2'b01)
                 && (block_in[25:2] == lane_bytes(2'(i)))
                 && (block_in[57:34] == ~lane_bytes(2'(i)));
    end
  end

  always_comb begin
    hit_any = |lane_hit;
    hit_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (lane_hit[i]) hit_idx = 2'(i);
    end
  end

  assign exp_pos = block_valid && (cnt_q == CW'(AM_PERIOD));
  assign hit_lid = lane_hit[lane_id_q];
  assign hit_rec = lane_hit[rec_q];
  assign am_take = block_valid && (state_q == LOCKED)
                && exp_pos && hit_lid;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    inv_d     = inv_q;
    rec_d     = rec_q;
    lane_id_d = lane_id_q;
    am_lock_d = am_lock_q;

    unique case (state_q)
      INIT: begin
        if (block_locked) state_d = FIND_1ST;
      end
      FIND_1ST: begin
        if (block_valid && hit_any) begin
          rec_d   = hit_idx;
          cnt_d   = CW'(1);
          state_d = COUNT_1;
        end
      end
      COUNT_1: begin
        if (exp_pos) begin
          cnt_d = CW'(1);
          if (hit_rec) begin
            state_d   = LOCKED;
            am_lock_d = 1'b1;
            lane_id_d = rec_q;
          end else begin
            state_d = FIND_1ST;
          end
        end else if (block_valid) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      LOCKED: begin
        if (exp_pos) begin
          cnt_d = CW'(1);
          if (hit_lid) begin
            inv_d = 3'd0;
          end else if (inv_q == 3'd3) begin
            inv_d     = 3'd0;
            am_lock_d = 1'b0;
            state_d   = FIND_1ST;
          end else begin
            inv_d = inv_q + 3'd1;
          end
        end else if (block_valid) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase

    // losing block sync overrides everything above
    if (!block_locked) begin
      state_d   = INIT;
      am_lock_d = 1'b0;
      cnt_d     = '0;
      inv_d     = 3'd0;
    end
  end

  always_comb begin
    bov_d       = block_valid && !am_take;
    am_strobe_d = am_take;
    bout_d      = block_valid ? block_in : bout_q;
  end

  always_ff @(posedge core_clk) begin
    if (!core_reset_n) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      inv_q       <= 3'd0;
      rec_q       <= 2'd0;
      lane_id_q   <= 2'd0;
      am_lock_q   <= 1'b0;
      am_strobe_q <= 1'b0;
      bov_q       <= 1'b0;
      bout_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      inv_q       <= inv_d;
      rec_q       <= rec_d;
      lane_id_q   <= lane_id_d;
      am_lock_q   <= am_lock_d;
      am_strobe_q <= am_strobe_d;
      bov_q       <= bov_d;
      bout_q      <= bout_d;
    end
  end

  assign block_out       = bout_q;
  assign block_out_valid = bov_q;
  assign am_strobe       = am_strobe_q;
  assign am_lock         = am_lock_q;
  assign lane_id         = lane_id_q;

endmodule

// File: tb/tb_rx_am_lock.sv
// Directed bench for rx_am_lock with AM_PERIOD=16.
// Acquisition, steady lock, miss handling, wrong lane, drop and reset.
module tb_rx_am_lock;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        blk_lock;
  logic        valid;
  logic [65:0] bin;
  logic [65:0] bout;
  logic        bov;
  logic        strobe;
  logic        lock;
  logic [1:0]  lid;

  int checks = 0;
  int errors = 0;
  int seq = 0;
  logic [65:0] last;

  rx_am_lock #(.AM_PERIOD(16)) dut (
    .core_clk(clk),
    .core_reset_n(rst_n),
    .block_locked(blk_lock),
    .block_valid(valid),
    .block_in(bin),
    .block_out(bout),
    .block_out_valid(bov),
    .am_strobe(strobe),
    .am_lock(lock),
    .lane_id(lid)
  );

  always #5 clk = ~clk;

  function automatic logic [65:0] am(input int lane, input logic [7:0] bip);
    logic [7:0] m0, m1, m2;
    m0 = 8'h00; m1 = 8'h00; m2 = 8'h00;
    case (lane)
      0: begin m0 = 8'h90; m1 = 8'h76; m2 = 8'h47; end
      1: begin m0 = 8'hF0; m1 = 8'hC4; m2 = 8'hE6; end
      2: begin m0 = 8'hC5; m1 = 8'h65; m2 = 8'h9B; end
      default: begin m0 = 8'hA2; m1 = 8'h79; m2 = 8'h3D; end
    endcase
    return {bip, ~m2, ~m1, ~m0, bip ^ 8'h5A, m2, m1, m0, 2'b01};
  endfunction

  function automatic logic [65:0] dat(input int i);
    logic [63:0] p;
    p = 64'hD0C0_0000_0000_0000 + 64'(i);
    return {p, 2'b10};
  endfunction

  task automatic chk(input string tag, input logic [65:0] obs,
                     input logic [65:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [65:0] b);
    valid = v;
    bin   = b;
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input string tag, input logic [65:0] b,
                      input logic e_bov, input logic e_str,
                      input logic e_lock, input logic [1:0] e_lid);
    step(1'b1, b);
    last = b;
    chk({tag, ".out"}, bout, b);
    chk({tag, ".bov"}, 66'(bov), 66'(e_bov));
    chk({tag, ".strobe"}, 66'(strobe), 66'(e_str));
    chk({tag, ".lock"}, 66'(lock), 66'(e_lock));
    chk({tag, ".lane"}, 66'(lid), 66'(e_lid));
  endtask

  task automatic data_run(input string tag, input int n,
                          input logic e_lock, input logic [1:0] e_lid);
    for (int i = 0; i < n; i++) begin
      xfer(tag, dat(seq), 1'b1, 1'b0, e_lock, e_lid);
      seq++;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    blk_lock = 1'b0;
    valid    = 1'b1;
    bin      = dat(500);
    last     = '0;

    // reset with a valid block present
    step(1'b1, dat(500));
    step(1'b1, dat(501));
    chk("rst.out", bout, 66'd0);
    chk("rst.bov", 66'(bov), 66'd0);
    chk("rst.strobe", 66'(strobe), 66'd0);
    chk("rst.lock", 66'(lock), 66'd0);
    chk("rst.lane", 66'(lid), 66'd0);

    rst_n    = 1'b1;
    blk_lock = 1'b1;
    step(1'b0, '0);

    // acquisition on lane 2 with an idle gap in the middle
    xfer("acq.am1", am(2, 8'h11), 1'b1, 1'b0, 1'b0, 2'd0);
    data_run("acq.d", 7, 1'b0, 2'd0);
    step(1'b0, dat(999));
    chk("gap.hold", bout, last);
    chk("gap.bov", 66'(bov), 66'd0);
    data_run("acq.d", 8, 1'b0, 2'd0);
    xfer("acq.am2", am(2, 8'h22), 1'b1, 1'b0, 1'b1, 2'd2);

    // steady lock, including an AM at a non-expected slot
    data_run("st.d", 4, 1'b1, 2'd2);
    xfer("st.stray", am(2, 8'h33), 1'b1, 1'b0, 1'b1, 2'd2);
    data_run("st.d", 10, 1'b1, 2'd2);
    xfer("st.am", am(2, 8'h44), 1'b0, 1'b1, 1'b1, 2'd2);
    data_run("st.d", 15, 1'b1, 2'd2);
    xfer("st.am", am(2, 8'hFF), 1'b0, 1'b1, 1'b1, 2'd2);

    // three misses then a good AM keeps lock
    for (int k = 0; k < 3; k++) begin
      data_run("rec.d", 15, 1'b1, 2'd2);
      xfer("rec.miss", dat(700 + k), 1'b1, 1'b0, 1'b1, 2'd2);
    end
    data_run("rec.d", 15, 1'b1, 2'd2);
    xfer("rec.am", am(2, 8'h55), 1'b0, 1'b1, 1'b1, 2'd2);

    // three more misses stay locked, fourth unlocks
    for (int k = 0; k < 3; k++) begin
      data_run("loss.d", 15, 1'b1, 2'd2);
      xfer("loss.miss", dat(710 + k), 1'b1, 1'b0, 1'b1, 2'd2);
    end
    data_run("loss.d", 15, 1'b1, 2'd2);
    xfer("loss.4th", dat(713), 1'b1, 1'b0, 1'b0, 2'd2);

    // wrong lane at the confirm slot
    xfer("wl.am1", am(1, 8'h01), 1'b1, 1'b0, 1'b0, 2'd2);
    data_run("wl.d", 15, 1'b0, 2'd2);
    xfer("wl.am3", am(3, 8'h02), 1'b1, 1'b0, 1'b0, 2'd2);
    data_run("wl.d", 15, 1'b0, 2'd2);
    xfer("wl.am3b", am(3, 8'h03), 1'b1, 1'b0, 1'b0, 2'd2);
    data_run("wl.d", 15, 1'b0, 2'd2);
    xfer("wl.lock3", am(3, 8'h04), 1'b1, 1'b0, 1'b1, 2'd3);

    // block sync drop for one cycle while locked
    blk_lock = 1'b0;
    xfer("drop", dat(800), 1'b1, 1'b0, 1'b0, 2'd3);
    blk_lock = 1'b1;
    step(1'b0, '0);
    chk("drop.idle", 66'(bov), 66'd0);

    // corrupted inverse byte is not an AM
    begin
      logic [65:0] bad;
      bad = am(0, 8'h66);
      bad[40] = ~bad[40];
      xfer("bad.am", bad, 1'b1, 1'b0, 1'b0, 2'd3);
    end
    data_run("bad.d", 15, 1'b0, 2'd3);
    xfer("l0.am1", am(0, 8'h77), 1'b1, 1'b0, 1'b0, 2'd3);
    data_run("l0.d", 15, 1'b0, 2'd3);
    xfer("l0.am2", am(0, 8'h88), 1'b1, 1'b0, 1'b1, 2'd0);
    data_run("l0.d", 15, 1'b1, 2'd0);
    xfer("l0.am3", am(0, 8'h99), 1'b0, 1'b1, 1'b1, 2'd0);
    data_run("l0.d", 15, 1'b1, 2'd0);

    // reset edge lands on an expected AM slot
    rst_n = 1'b0;
    step(1'b1, am(0, 8'hAA));
    chk("mrst.out", bout, 66'd0);
    chk("mrst.bov", 66'(bov), 66'd0);
    chk("mrst.strobe", 66'(strobe), 66'd0);
    chk("mrst.lock", 66'(lock), 66'd0);
    chk("mrst.lane", 66'(lid), 66'd0);
    step(1'b1, dat(900));
    chk("mrst2.out", bout, 66'd0);
    chk("mrst2.lock", 66'(lock), 66'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
